mat_result_unloader: RTL and testbench
======================================

# mat_result_unloader

Drains a completed systolic-array result matrix into a valid/ready element stream. Sits directly after `control`: captures the flat `o_C` bus on the `o_done` pulse, then emits the N*N W-bit elements one per accepted beat in row-major order (column-major under a build option). It lets a narrow consumer (DMA, host FIFO, checker) read results while `control` is re-armed for the next multiply.

## Interface
- `W`, default 16, element width in bits (fp16 bit pattern, passed through untouched).
- `N`, default 3, matrix dimension; `N >= 1`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_done`  in  1  one-cycle pulse from `control` `o_done`; `i_C` is valid in that cycle.
- `i_C`  in  W*N*N  result matrix. Element (r,c) sits at bits `[W*(N*N-1-(r*N+c)) +: W]`, so (0,0) occupies the MSBs.
- `o_data`  out  W  current element.
- `o_valid`  out  1  `o_data` is valid.
- `i_ready`  in  1  consumer accepts `o_data` this cycle.
- `o_last`  out  1  high with `o_valid` on the final element (N*N-th beat).
- `o_row`  out  max(1,$clog2(N))  row index of `o_data`.
- `o_col`  out  max(1,$clog2(N))  column index of `o_data`.
- `o_busy`  out  1  high from capture until the final beat transfers.
- `o_overrun`  out  1  one-cycle pulse when an `i_done` is dropped.

## Operation
- FSM states: IDLE and STREAM.
- IDLE: `o_valid` is 0. When `i_done` = 1, register all of `i_C` into an internal N*N*W buffer, clear the element index, and go to STREAM.
- STREAM: `o_valid` is 1. `o_data`, `o_row`, `o_col` and `o_last` are taken from the buffer at the current index.
- A transfer occurs on a cycle where `o_valid && i_ready`. On a transfer:
  - If it is not the last element, the index increments.
  - If it is the last element, return to IDLE.
- Backpressure: while `o_valid && !i_ready`, `o_data`, `o_row`, `o_col` and `o_last` hold stable.
- Index counter width is max(1,$clog2(N*N)). Row/column counters wrap column-first:
  - col goes 0..N-1, then resets to 0 and row increments.
  - No division is used.
- Simultaneous final transfer and `i_done`: capture the new `i_C`, reset the index to 0, and stay in STREAM. `o_valid` stays 1 with no bubble.
- `i_done` during STREAM on any other cycle: the pulse is ignored, the buffer is unchanged, and `o_overrun` = 1 for the next cycle.
- Reset (at any time, including mid-stream):
  - Outputs: `o_valid`, `o_last`, `o_busy`, `o_overrun` = 0; `o_data` = 0; `o_row`, `o_col` = 0.
  - State returns to IDLE and the buffer is cleared.
  - The partial stream is abandoned with no further beats.

## Timing
- Capture latency: `i_done` at edge k gives `o_valid` = 1 with element (0,0) after edge k+1.
- Throughput: one element per cycle when `i_ready` is held high. A full matrix takes N*N cycles after the first valid.
- `o_busy` equals `o_valid`. It is registered, not combinational from `i_ready`.
- `o_overrun` is registered and lasts one cycle per dropped pulse.
- `o_valid` has no combinational dependence on `i_ready`. `o_data` may be a buffer mux on the registered index.

## Configuration
- `MAT_UNLOAD_TRANSPOSE_EN`:
  - Defined: elements stream column-major, i.e. (0,0),(1,0),...,(N-1,0),(0,1),... The row counter wraps first. `o_row`/`o_col` still report the true indices, and `o_last` marks (N-1,N-1).
  - Undefined: row-major as specified above.
  - Capture, handshake and overrun behaviour are identical in both builds.

## Test plan
- W=16, N=3: `i_C` = nine 16'h4200 (3.0), `i_ready` held 1 → nine beats of 16'h4200 on consecutive cycles. `o_last` is high only on beat 9 (row 2, col 2). `o_valid` drops the cycle after.
- `i_C` elements 16'h0001..16'h0009 packed (0,0)..(2,2) → `o_data` sequence 1..9 with (row,col) = (0,0),(0,1),...,(2,2). Under `MAT_UNLOAD_TRANSPOSE_EN` the sequence is 1,4,7,2,5,8,3,6,9.
- Toggle `i_ready` 1,0,0,1,... → no element is skipped or duplicated, and `o_data` is stable during every stall cycle.
- Pulse `i_done` on beat 4 → `o_overrun` pulses once and the remaining beats still carry the original matrix. A second `i_done` exactly on the final transfer → the next cycle shows the new (0,0) element with `o_valid` continuously high.
- Assert `i_rst` after beat 5 → all outputs are 0 immediately. After release, a new `i_done` restarts the stream from (0,0).

Source files
------------

// File: rtl/mat_result_unloader.sv
// Drains a captured N*N result matrix as a valid/ready element stream, row-major by default.
// Define MAT_UNLOAD_TRANSPOSE_EN to stream column-major instead.
module mat_result_unloader #(
   parameter int W  = 16,
   parameter int N  = 3,
   localparam int RW = (N > 1) ? $clog2(N) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_done,
   input  logic [W*N*N-1:0]   i_C,
   output logic [W-1:0]       o_data,
   output logic               o_valid,
   input  logic               i_ready,
   output logic               o_last,
   output logic [RW-1:0]      o_row,
   output logic [RW-1:0]      o_col,
   output logic               o_busy,
   output logic               o_overrun
);

   localparam int NE = N * N;
   localparam int IW = (NE > 1) ? $clog2(NE) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   logic [0:0]        state_p0;
   logic [W*NE-1:0]   mat_p0;
   logic [IW-1:0]     idx_p0;
   logic [RW-1:0]     row_p0;
   logic [RW-1:0]     col_p0;
   logic              ovr_p0;

   logic              vld_p0;
   logic              xfer;
   logic              at_last;
   logic [W-1:0]      elem;

   assign vld_p0  = (state_p0 == STREAM);
   assign xfer    = vld_p0 && i_ready;
   assign at_last = (idx_p0 == IW'(NE - 1));

   // Capture / stream state: index, row/col and buffer all registered
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_p0 <= IDLE;
         mat_p0   <= '0;
         idx_p0   <= '0;
         row_p0   <= '0;
         col_p0   <= '0;
         ovr_p0   <= 1'b0;
      end else begin
         // A pulse coinciding with the final transfer is a legal back-to-back capture
         ovr_p0 <= vld_p0 && i_done && !(xfer && at_last);
         case (state_p0)
            IDLE: begin
               if (i_done) begin
                  mat_p0   <= i_C;
                  idx_p0   <= '0;
                  row_p0   <= '0;
                  col_p0   <= '0;
                  state_p0 <= STREAM;
               end
            end
            STREAM: begin
               if (xfer) begin
                  if (at_last) begin
                     idx_p0 <= '0;
                     row_p0 <= '0;
                     col_p0 <= '0;
                     if (i_done) begin
                        mat_p0 <= i_C;
                     end else begin
                        state_p0 <= IDLE;
                     end
                  end else begin
                     idx_p0 <= idx_p0 + 1'b1;
`ifdef MAT_UNLOAD_TRANSPOSE_EN
                     if (row_p0 == RW'(N - 1)) begin
                        row_p0 <= '0;
                        col_p0 <= col_p0 + 1'b1;
                     end else begin
                        row_p0 <= row_p0 + 1'b1;
                     end
`else
                     if (col_p0 == RW'(N - 1)) begin
                        col_p0 <= '0;
                        row_p0 <= row_p0 + 1'b1;
                     end else begin
                        col_p0 <= col_p0 + 1'b1;
                     end
`endif
                  end
               end
            end
            default: state_p0 <= IDLE;
         endcase
      end
   end

   // Output select: element (row,col) from the buffer, (0,0) in the MSBs
   always_comb begin
      elem = '0;
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            if (row_p0 == RW'(r) && col_p0 == RW'(c)) begin
               elem = mat_p0[W*(NE-1-(r*N+c)) +: W];
            end
         end
      end
   end

   assign o_valid   = vld_p0;
   assign o_busy    = vld_p0;
   assign o_last    = vld_p0 && at_last;
   assign o_data    = vld_p0 ? elem : '0;
   assign o_row     = row_p0;
   assign o_col     = col_p0;
   assign o_overrun = ovr_p0;

endmodule

// File: tb/tb_mat_result_unloader.sv
// Directed bench for mat_result_unloader with a beat-level reference model.
module tb_mat_result_unloader;

   localparam int W  = 16;
   localparam int N  = 3;
   localparam int NE = N * N;
   localparam int RW = 2;

   logic              clk = 1'b0;
   logic              i_rst;
   logic              i_done;
   logic [W*NE-1:0]   i_C;
   logic [W-1:0]      o_data;
   logic              o_valid;
   logic              i_ready;
   logic              o_last;
   logic [RW-1:0]     o_row;
   logic [RW-1:0]     o_col;
   logic              o_busy;
   logic              o_overrun;

   int total = 0;
   int bad   = 0;

   mat_result_unloader #(.W(W), .N(N)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_done(i_done), .i_C(i_C),
      .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
      .o_row(o_row), .o_col(o_col), .o_busy(o_busy), .o_overrun(o_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: active flag, beat number and a copy of the matrix
   logic [W-1:0] m_mat [N][N];
   bit           m_active;
   int           m_k;
   bit           m_ovr;

   always @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         m_active = 0; m_k = 0; m_ovr = 0;
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) m_mat[r][c] = '0;
      end else begin
         bit xf, lst, load;
         xf   = m_active && i_ready;
         lst  = (m_k == NE - 1);
         load = 0;
         m_ovr = m_active && i_done && !(xf && lst);
         if (!m_active) begin
            if (i_done) begin load = 1; m_active = 1; m_k = 0; end
         end else if (xf) begin
            if (lst) begin
               m_k = 0;
               if (i_done) load = 1; else m_active = 0;
            end else begin
               m_k = m_k + 1;
            end
         end
         if (load)
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++) m_mat[r][c] = i_C[W*(NE-1-(r*N+c)) +: W];
      end
   end

   typedef struct packed {
      logic [W-1:0]  d;
      logic [RW-1:0] r;
      logic [RW-1:0] c;
      logic          l;
   } beat_t;

   beat_t        log_q[$];
   int           ovr_cnt = 0;
   int           drops   = 0;
   bit           prev_valid = 0;
   bit           prev_stall = 0;
   logic [W-1:0] stall_d;
   logic [RW-1:0] stall_r, stall_c;

   always @(negedge clk) begin
      int r, c;
      chk("valid", o_valid, m_active);
      chk("busy", o_busy, m_active);
      chk("overrun", o_overrun, m_ovr);
      if (m_active) begin
`ifdef MAT_UNLOAD_TRANSPOSE_EN
         c = m_k / N; r = m_k % N;
`else
         r = m_k / N; c = m_k % N;
`endif
         chk("data", o_data, m_mat[r][c]);
         chk("row", o_row, r);
         chk("col", o_col, c);
         chk("last", o_last, (m_k == NE - 1));
      end else begin
         chk("last_idle", o_last, 0);
      end
      if (prev_stall) begin
         chk("stall_data", o_data, stall_d);
         chk("stall_row", o_row, stall_r);
         chk("stall_col", o_col, stall_c);
      end
      prev_stall = o_valid && !i_ready && !i_rst;
      stall_d = o_data; stall_r = o_row; stall_c = o_col;
      if (o_overrun) ovr_cnt++;
      if (prev_valid && !o_valid) drops++;
      prev_valid = o_valid;
      if (o_valid && i_ready && !i_rst) log_q.push_back('{d: o_data, r: o_row, c: o_col, l: o_last});
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic [W*NE-1:0] m);
      i_C = m;
      i_done = 1'b1;
      step();
      i_done = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (o_valid && n < 100) begin
         step();
         n++;
      end
      chk(name, (n < 100), 1);
   endtask

   function automatic logic [W*NE-1:0] pack_seq(input logic [W-1:0] base, input bit same);
      logic [W*NE-1:0] v;
      for (int e = 0; e < NE; e++) v[W*(NE-1-e) +: W] = same ? base : W'(int'(base) + e + 1);
      return v;
   endfunction

   logic [W*NE-1:0] mat_a, mat_b;
   int exp_d[9];
   int exp_r[9];
   int exp_c[9];
   int pat[4];

   initial begin
`ifdef MAT_UNLOAD_TRANSPOSE_EN
      exp_d = '{1, 4, 7, 2, 5, 8, 3, 6, 9};
      exp_r = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
      exp_c = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
`else
      exp_d = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
      exp_r = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
      exp_c = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif
      pat   = '{1, 0, 0, 1};
      mat_a = pack_seq(16'h0000, 0);
      mat_b = pack_seq(16'h0100, 0);

      i_rst = 1'b1; i_done = 1'b0; i_C = '0; i_ready = 1'b0;
      step(); step();
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      i_rst = 1'b0;
      step();

      // All-3.0 matrix, ready held high
      i_ready = 1'b1;
      log_q.delete();
      pulse(pack_seq(16'h4200, 1));
      chk("first_valid", o_valid, 1);
      drain("drain1");
      chk("t1_beats", log_q.size(), 9);
      foreach (log_q[i]) begin
         chk("t1_data", log_q[i].d, 16'h4200);
         chk("t1_last", log_q[i].l, (i == 8));
      end
      chk("t1_end_rc", {log_q[8].r, log_q[8].c}, 4'b1010);
      chk("t1_idle", o_valid, 0);

      // Sequence 1..9
      log_q.delete();
      pulse(mat_a);
      drain("drain2");
      chk("t2_beats", log_q.size(), 9);
      foreach (log_q[i]) begin
         chk("t2_data", log_q[i].d, exp_d[i]);
         chk("t2_row", log_q[i].r, exp_r[i]);
         chk("t2_col", log_q[i].c, exp_c[i]);
      end

      // Ready toggling 1,0,0,1
      log_q.delete();
      pulse(mat_a);
      begin
         int cyc = 0;
         while (o_valid && cyc < 100) begin
            i_ready = pat[cyc % 4][0];
            step();
            cyc++;
         end
         chk("drain3", (cyc < 100), 1);
      end
      i_ready = 1'b1;
      chk("t3_beats", log_q.size(), 9);
      foreach (log_q[i]) chk("t3_data", log_q[i].d, exp_d[i]);

      // Dropped pulse on beat 4, back-to-back capture on the final transfer
      log_q.delete();
      ovr_cnt = 0;
      drops = 0;
      pulse(mat_a);
      repeat (3) step();
      pulse(mat_b);
      repeat (4) step();
      chk("t4_beat9_last", o_last, 1);
      pulse(mat_b);
      chk("t4_b00_valid", o_valid, 1);
      chk("t4_b00_data", o_data, 16'h0101);
      drain("drain4");
      chk("t4_overruns", ovr_cnt, 1);
      chk("t4_drops", drops, 1);
      chk("t4_beats", log_q.size(), 18);
      chk("t4_a_last", log_q[8].d, 16'h0009);
      chk("t4_a_beat5", log_q[4].d, 16'h0005);
      chk("t4_b_first", log_q[9].d, 16'h0101);
      chk("t4_b_final", log_q[17].d, 16'h0109);

      // Reset mid-stream after beat 5
      log_q.delete();
      pulse(mat_a);
      repeat (5) step();
      chk("t5_pre_valid", o_valid, 1);
      i_rst = 1'b1;
      #1;
      chk("t5_valid", o_valid, 0);
      chk("t5_last", o_last, 0);
      chk("t5_busy", o_busy, 0);
      chk("t5_ovr", o_overrun, 0);
      chk("t5_data", o_data, 0);
      chk("t5_row", o_row, 0);
      chk("t5_col", o_col, 0);
      step(); step();
      i_rst = 1'b0;
      step(); step();
      chk("t5_no_beats", log_q.size(), 5);
      log_q.delete();
      pulse(mat_b);
      drain("drain5");
      chk("t5_beats", log_q.size(), 9);
      chk("t5_first", log_q[0].d, 16'h0101);
      chk("t5_first_rc", {log_q[0].r, log_q[0].c}, 0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
